// File: rtl/aib_avmm_pkg.sv
// Shared types and constants for the AIB AVMM channel bridge.
package aib_avmm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FWD,
    ST_ACK,
    ST_RDWAIT,
    ST_RESP
  } avmm_state_e;

  // Returned on reads that hit a decode error or a timeout.
  localparam logic [31:0] ERR_DATA = 32'hDEAD_0BAD;

  // Width of the channel-select field; at least one bit so a
  // single-channel build still has a legal index register.
  function automatic int csel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aib_avmm_chnl_mux.sv
// Purely combinational selection of one channel's response signals.
module aib_avmm_chnl_mux #(
  parameter int NBR_CHNLS = 24,
  parameter int DATA_W    = 32,
  parameter int CSEL_W    = 5
) (
  input  logic [CSEL_W-1:0]           sel_idx,
  input  logic [NBR_CHNLS-1:0]        chnl_waitreq,
  input  logic [NBR_CHNLS-1:0]        chnl_rdatavld,
  input  logic [DATA_W*NBR_CHNLS-1:0] chnl_rdata,
  output logic                        sel_waitreq,
  output logic                        sel_rdatavld,
  output logic [DATA_W-1:0]           sel_rdata
);

  // Out-of-range indices look like a channel that never answers.
  always_comb begin
    sel_waitreq  = 1'b1;
    sel_rdatavld = 1'b0;
    sel_rdata    = '0;
    for (int n = 0; n < NBR_CHNLS; n++) begin
      if (sel_idx == CSEL_W'(n)) begin
        sel_waitreq  = chnl_waitreq[n];
        sel_rdatavld = chnl_rdatavld[n];
        sel_rdata    = chnl_rdata[n*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/aib_avmm_chnl_bridge.sv
// Sequential AVMM bridge: one top-level config port fanned out to
// NBR_CHNLS channel slaves, one transaction in flight, with timeout
// and decode-error recovery so the master is never stalled.
module aib_avmm_chnl_bridge
  import aib_avmm_pkg::*;
#(
  parameter int NBR_CHNLS    = 24,
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 17,
  parameter int CHNL_SEL_LSB = 11,
  parameter int TIMEOUT      = 255
) (
  input  logic                        i_cfg_avmm_clk,
  input  logic                        i_cfg_avmm_rst,
  input  logic [ADDR_W-1:0]           i_cfg_avmm_addr,
  input  logic                        i_cfg_avmm_read,
  input  logic                        i_cfg_avmm_write,
  input  logic [DATA_W-1:0]           i_cfg_avmm_wdata,
  input  logic [DATA_W/8-1:0]         i_cfg_avmm_byte_en,
  output logic                        o_cfg_avmm_waitreq,
  output logic                        o_cfg_avmm_rdatavld,
  output logic [DATA_W-1:0]           o_cfg_avmm_rdata,
  output logic [NBR_CHNLS-1:0]        o_chnl_read,
  output logic [NBR_CHNLS-1:0]        o_chnl_write,
  output logic [CHNL_SEL_LSB-1:0]     o_chnl_addr,
  output logic [DATA_W-1:0]           o_chnl_wdata,
  output logic [DATA_W/8-1:0]         o_chnl_byte_en,
  input  logic [NBR_CHNLS-1:0]        i_chnl_waitreq,
  input  logic [NBR_CHNLS-1:0]        i_chnl_rdatavld,
  input  logic [DATA_W*NBR_CHNLS-1:0] i_chnl_rdata,
  input  logic                        i_err_clr,
  output logic                        o_timeout_err,
  output logic                        o_decode_err
);

  localparam int CSEL_W = csel_width(NBR_CHNLS);
  localparam int CNT_W  = csel_width(TIMEOUT);
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

  avmm_state_e state_reg, state_next;

  logic              wr_reg;     // latched command: 1 = write, 0 = read
  logic [CSEL_W-1:0] idx_reg;    // latched channel index
  logic              abort_reg;  // read must answer with ERR_WORD
  logic [CNT_W-1:0]  cnt_reg;    // cycles spent in FWD / RDWAIT

  logic              req;
  logic [CSEL_W-1:0] addr_idx;
  logic              addr_bad;
  logic              timed_out;
  logic              sel_waitreq, sel_rdatavld;
  logic [DATA_W-1:0] sel_rdata;

  logic [CSEL_W-1:0]    cur_idx;
  logic                 cur_wr;
  logic [NBR_CHNLS-1:0] hit;
  logic [NBR_CHNLS-1:0] rd_strobe_next, wr_strobe_next;
  logic                 waitreq_next, rdatavld_next;
  logic [DATA_W-1:0]    rdata_next;
  logic                 timeout_set, decode_set;

  assign req       = i_cfg_avmm_read | i_cfg_avmm_write;
  assign addr_idx  = i_cfg_avmm_addr[CHNL_SEL_LSB +: CSEL_W];
  assign addr_bad  = (int'(addr_idx) >= NBR_CHNLS);
  assign timed_out = (cnt_reg == CNT_W'(TIMEOUT - 1));

  // Address bits above the channel field carry no meaning here.
  if (ADDR_W > CHNL_SEL_LSB + CSEL_W) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^i_cfg_avmm_addr[ADDR_W-1:CHNL_SEL_LSB+CSEL_W];
  end

  aib_avmm_chnl_mux #(
    .NBR_CHNLS (NBR_CHNLS),
    .DATA_W    (DATA_W),
    .CSEL_W    (CSEL_W)
  ) u_mux (
    .sel_idx       (idx_reg),
    .chnl_waitreq  (i_chnl_waitreq),
    .chnl_rdatavld (i_chnl_rdatavld),
    .chnl_rdata    (i_chnl_rdata),
    .sel_waitreq   (sel_waitreq),
    .sel_rdatavld  (sel_rdatavld),
    .sel_rdata     (sel_rdata)
  );

  // Strobes are registered, so the index must be taken from the live
  // address on the IDLE->FWD edge and from the latch afterwards.
  assign cur_idx = (state_reg == ST_IDLE) ? addr_idx : idx_reg;
  assign cur_wr  = (state_reg == ST_IDLE) ? i_cfg_avmm_write : wr_reg;

  for (genvar gi = 0; gi < NBR_CHNLS; gi++) begin : g_hit
    assign hit[gi] = (cur_idx == CSEL_W'(gi));
  end

  // State register.
  always_ff @(posedge i_cfg_avmm_clk) begin
    if (i_cfg_avmm_rst) state_reg <= ST_IDLE;
    else                state_reg <= state_next;
  end

  // Next-state logic; a timeout is just another exit from FWD/RDWAIT.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (req) state_next = addr_bad ? ST_ACK : ST_FWD;
      ST_FWD:    if (!sel_waitreq || timed_out) state_next = ST_ACK;
      ST_ACK: begin
        if (wr_reg)         state_next = ST_IDLE;
        else if (abort_reg) state_next = ST_RESP;
        else                state_next = ST_RDWAIT;
      end
      ST_RDWAIT: if (sel_rdatavld || timed_out) state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs.
  always_comb begin
    waitreq_next   = (state_next != ST_ACK);
    rdatavld_next  = (state_next == ST_RESP);
    rdata_next     = o_cfg_avmm_rdata;
    if (state_next == ST_RESP)
      rdata_next = (state_reg == ST_RDWAIT && sel_rdatavld) ? sel_rdata : ERR_WORD;
    wr_strobe_next = (state_next == ST_FWD &&  cur_wr) ? hit : '0;
    rd_strobe_next = (state_next == ST_FWD && !cur_wr) ? hit : '0;
    timeout_set    = timed_out &&
                     ((state_reg == ST_FWD    &&  sel_waitreq) ||
                      (state_reg == ST_RDWAIT && !sel_rdatavld));
    decode_set     = (state_reg == ST_IDLE) && req && addr_bad;
  end

  // Transaction context and the per-state cycle counter.
  always_ff @(posedge i_cfg_avmm_clk) begin
    if (i_cfg_avmm_rst) begin
      wr_reg    <= 1'b0;
      idx_reg   <= '0;
      abort_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      if (state_reg == ST_IDLE && req) begin
        wr_reg    <= i_cfg_avmm_write;
        idx_reg   <= addr_idx;
        abort_reg <= addr_bad;
      end else if (timeout_set) begin
        abort_reg <= 1'b1;
      end
      if (state_next != state_reg)
        cnt_reg <= '0;
      else if (state_reg == ST_FWD || state_reg == ST_RDWAIT)
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Registered outputs; an error set beats a same-cycle clear.
  always_ff @(posedge i_cfg_avmm_clk) begin
    if (i_cfg_avmm_rst) begin
      o_cfg_avmm_waitreq  <= 1'b1;
      o_cfg_avmm_rdatavld <= 1'b0;
      o_cfg_avmm_rdata    <= '0;
      o_chnl_read         <= '0;
      o_chnl_write        <= '0;
      o_chnl_addr         <= '0;
      o_chnl_wdata        <= '0;
      o_chnl_byte_en      <= '0;
      o_timeout_err       <= 1'b0;
      o_decode_err        <= 1'b0;
    end else begin
      o_cfg_avmm_waitreq  <= waitreq_next;
      o_cfg_avmm_rdatavld <= rdatavld_next;
      o_cfg_avmm_rdata    <= rdata_next;
      o_chnl_read         <= rd_strobe_next;
      o_chnl_write        <= wr_strobe_next;
      if (state_reg == ST_IDLE && req) begin
        o_chnl_addr    <= i_cfg_avmm_addr[CHNL_SEL_LSB-1:0];
        o_chnl_wdata   <= i_cfg_avmm_wdata;
        o_chnl_byte_en <= i_cfg_avmm_byte_en;
      end
      if (timeout_set)    o_timeout_err <= 1'b1;
      else if (i_err_clr) o_timeout_err <= 1'b0;
      if (decode_set)     o_decode_err  <= 1'b1;
      else if (i_err_clr) o_decode_err  <= 1'b0;
    end
  end

endmodule
